// File: rtl/fcl1_pxl_packer.sv
// Collects pooled conv1 beats, requantizes them to 8-bit pixels, and presents one
// complete NUM_FILT x NUM_PXL frame to FCL1 until FCL1 asks for the next one.

module fcl1_pxl_requant #(
  parameter int IW     = 22,
  parameter int OW     = 8,
  parameter int QSHIFT = 8
) (
  input  logic [IW-1:0] op_i,
  output logic [OW-1:0] pxl_o
);
  logic [IW-1:0] q;
  assign q     = op_i >> QSHIFT;
  assign pxl_o = (q > IW'((1 << OW) - 1)) ? '1 : q[OW-1:0];
endmodule

module fcl1_pxl_packer #(
  parameter int NUM_FILT     = 6,
  parameter int NUM_PXL      = 100,
  parameter int PXL_PER_BEAT = 2,
  parameter int OPERAND_WDTH = 22,
  parameter int PXL_WIDTH    = 8,
  parameter int QSHIFT       = 8
) (
  input  logic fcl1_top_clk,
  input  logic fcl1_top_rst_b,
  input  logic pool_valid_i,
  input  logic pool_sof_i,
  input  logic [NUM_FILT-1:0][PXL_PER_BEAT-1:0][OPERAND_WDTH-1:0] pool_out_i,
  input  logic fcl_restart_i,
  output logic [NUM_FILT-1:0][NUM_PXL-1:0][PXL_WIDTH-1:0] fcl_pixel_data_o,
  output logic fcl_wake_o,
  output logic fcl_data_valid_o,
  output logic pkr_busy_o,
  output logic pkr_overflow_o,
  output logic pkr_sync_err_o
);
  localparam int BEATS = NUM_PXL / PXL_PER_BEAT;
  localparam int CW    = $clog2(BEATS);
  localparam int IW    = $clog2(NUM_PXL);

  typedef enum logic [1:0] {IDLE, FILL, READY} state_e;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, wr_beat;
  logic last_q, last_d, wake_q, wake_d, dv_q, dv_d, ovf_q, ovf_d, serr_q, serr_d;
  logic wr_en;
  logic [NUM_FILT-1:0][NUM_PXL-1:0][PXL_WIDTH-1:0] pix_q, pix_d;
  logic [NUM_FILT-1:0][PXL_PER_BEAT-1:0][PXL_WIDTH-1:0] rq;

  for (genvar f = 0; f < NUM_FILT; f++) begin : g_filt
    for (genvar p = 0; p < PXL_PER_BEAT; p++) begin : g_pxl
      fcl1_pxl_requant #(.IW(OPERAND_WDTH), .OW(PXL_WIDTH), .QSHIFT(QSHIFT)) u_rq (
        .op_i  (pool_out_i[f][p]),
        .pxl_o (rq[f][p])
      );
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = 1'b0;
    wake_d  = wake_q;
    dv_d    = 1'b0;
    ovf_d   = ovf_q;
    serr_d  = serr_q;
    wr_en   = 1'b0;
    wr_beat = cnt_q;
    case (state_q)
      IDLE: if (pool_valid_i) begin
        if (pool_sof_i) begin
          wr_en   = 1'b1;
          wr_beat = '0;
          cnt_d   = CW'(1);
          state_d = FILL;
        end else serr_d = 1'b1;
      end
      FILL: if (last_q) begin
        // Frame already complete; this cycle only publishes it, so a beat here has nowhere to go.
        state_d = READY;
        wake_d  = 1'b1;
        dv_d    = 1'b1;
        if (pool_valid_i) ovf_d = 1'b1;
      end else if (pool_valid_i) begin
        wr_en = 1'b1;
        if (pool_sof_i) begin
          wr_beat = '0;
          cnt_d   = CW'(1);
          serr_d  = 1'b1;
        end else if (cnt_q == CW'(BEATS - 1)) begin
          cnt_d  = '0;
          last_d = 1'b1;
        end else cnt_d = cnt_q + CW'(1);
      end
      READY: if (fcl_restart_i) begin
        wake_d  = 1'b0;
        state_d = IDLE;
        if (pool_valid_i && pool_sof_i) begin
          wr_en   = 1'b1;
          wr_beat = '0;
          cnt_d   = CW'(1);
          state_d = FILL;
        end else if (pool_valid_i) serr_d = 1'b1;
      end else if (pool_valid_i) ovf_d = 1'b1;
      default: state_d = IDLE;
    endcase

    pix_d = pix_q;
    if (wr_en)
      for (int f = 0; f < NUM_FILT; f++)
        for (int p = 0; p < PXL_PER_BEAT; p++)
          pix_d[f][IW'(PXL_PER_BEAT * int'(wr_beat) + p)] = rq[f][p];
  end

  always_ff @(posedge fcl1_top_clk or negedge fcl1_top_rst_b) begin
    if (!fcl1_top_rst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      wake_q  <= 1'b0;
      dv_q    <= 1'b0;
      ovf_q   <= 1'b0;
      serr_q  <= 1'b0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      wake_q  <= wake_d;
      dv_q    <= dv_d;
      ovf_q   <= ovf_d;
      serr_q  <= serr_d;
      pix_q   <= pix_d;
    end
  end

  assign fcl_pixel_data_o = pix_q;
  assign fcl_wake_o       = wake_q;
  assign fcl_data_valid_o = dv_q;
  assign pkr_busy_o       = (state_q == FILL);
  assign pkr_overflow_o   = ovf_q;
  assign pkr_sync_err_o   = serr_q;
endmodule

// File: tb/tb_fcl1_pxl_packer.sv
// Directed bench for fcl1_pxl_packer: frame fill, saturation, overflow, resync and reset abort.

module tb_fcl1_pxl_packer;
  typedef logic [5:0][1:0][21:0] pool_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic pool_valid = 1'b0, pool_sof = 1'b0, restart = 1'b0;
  pool_t pool_out = '0;
  logic [5:0][99:0][7:0] pix;
  logic wake, dv, busy, ovf, serr;
  int n_vec = 0, n_err = 0;

  fcl1_pxl_packer dut (
    .fcl1_top_clk     (clk),
    .fcl1_top_rst_b   (rst_n),
    .pool_valid_i     (pool_valid),
    .pool_sof_i       (pool_sof),
    .pool_out_i       (pool_out),
    .fcl_restart_i    (restart),
    .fcl_pixel_data_o (pix),
    .fcl_wake_o       (wake),
    .fcl_data_valid_o (dv),
    .pkr_busy_o       (busy),
    .pkr_overflow_o   (ovf),
    .pkr_sync_err_o   (serr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic pool_t mk(input logic [21:0] v);
    pool_t r;
    for (int f = 0; f < 6; f++)
      for (int p = 0; p < 2; p++) r[f][p] = v;
    return r;
  endfunction

  task automatic step(input logic v, input logic s, input logic r, input pool_t d);
    pool_valid = v;
    pool_sof   = s;
    restart    = r;
    pool_out   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    pool_t sb;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wake", wake, 0);
    chk("rst_dv", dv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_serr", serr, 0);
    chk("rst_pix", {63'd0, |pix}, 0);
    rst_n = 1'b1;
    idle();

    // Frame 1: beat k carries 0x100*(k+1) -> pixels k+1
    for (int k = 0; k < 50; k++) begin
      step(1'b1, k == 0, 1'b0, mk(22'(256 * (k + 1))));
      if (k == 0) chk("f1_busy", busy, 1);
    end
    chk("f1_wake_early", wake, 0);
    chk("f1_dv_early", dv, 0);
    idle();
    chk("f1_wake", wake, 1);
    chk("f1_dv", dv, 1);
    chk("f1_busy_rdy", busy, 0);
    idle();
    chk("f1_dv_pulse", dv, 0);
    chk("f1_wake_hold", wake, 1);
    for (int f = 0; f < 6; f++)
      for (int n = 0; n < 100; n++)
        chk($sformatf("f1_pix[%0d][%0d]", f, n), pix[f][n], n / 2 + 1);

    // Restart coincident with sof; beat 0 exercises saturation
    sb = mk(22'h000200);
    sb[0][0] = 22'h3FFFFF;
    sb[0][1] = 22'h00FFFF;
    sb[1][0] = 22'h0000FF;
    sb[1][1] = 22'h010000;
    step(1'b1, 1'b1, 1'b1, sb);
    chk("rs_wake", wake, 0);
    chk("rs_busy", busy, 1);
    chk("rs_ovf", ovf, 0);
    chk("sat_00", pix[0][0], 8'hFF);
    chk("sat_01", pix[0][1], 8'hFF);
    chk("sat_10", pix[1][0], 8'h00);
    chk("sat_11", pix[1][1], 8'hFF);
    chk("sat_20", pix[2][0], 8'h02);
    chk("rs_stale", pix[4][2], 2);
    for (int k = 1; k < 50; k++) step(1'b1, 1'b0, 1'b0, mk(22'(256 * (k + 1))));
    idle();
    chk("f2_wake", wake, 1);
    chk("f2_dv", dv, 1);
    chk("f2_pix_sat", pix[0][1], 8'hFF);
    chk("f2_pix_end", pix[3][99], 50);

    // Beat in READY without restart is dropped
    step(1'b1, 1'b0, 1'b0, mk(22'h3FFFFF));
    chk("ov_flag", ovf, 1);
    chk("ov_wake", wake, 1);
    chk("ov_keep0", pix[1][0], 8'h00);
    chk("ov_keep1", pix[3][10], 6);
    idle();
    chk("ov_sticky", ovf, 1);
    step(1'b0, 1'b0, 1'b1, '0);
    chk("rel_wake", wake, 0);
    chk("rel_busy", busy, 0);

    // Frame 3: resync at beat 20
    for (int k = 0; k < 20; k++) step(1'b1, k == 0, 1'b0, mk(22'(256 * (k + 1))));
    chk("f3_serr0", serr, 0);
    step(1'b1, 1'b1, 1'b0, mk(22'h007700));
    chk("f3_serr", serr, 1);
    chk("f3_busy", busy, 1);
    for (int j = 1; j < 50; j++) begin
      step(1'b1, 1'b0, 1'b0, mk(22'(256 * (j + 101))));
      if (j == 30) chk("f3_no_early_wake", wake, 0);
    end
    idle();
    chk("f3_wake", wake, 1);
    chk("f3_p00", pix[0][0], 8'h77);
    chk("f3_p51", pix[5][1], 8'h77);
    chk("f3_p02", pix[0][2], 102);
    chk("f3_p250", pix[2][50], 126);
    chk("f3_p599", pix[5][99], 150);
    step(1'b0, 1'b0, 1'b1, '0);

    // Reset aborts a partial frame
    for (int k = 0; k < 30; k++) step(1'b1, k == 0, 1'b0, mk(22'(256 * (k + 3))));
    rst_n = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_wake", wake, 0);
    chk("ar_ovf", ovf, 0);
    chk("ar_serr", serr, 0);
    chk("ar_pix", {63'd0, |pix}, 0);
    idle();
    idle();
    chk("ar_hold_busy", busy, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 50; k++) step(1'b1, k == 0, 1'b0, mk(22'(256 * (k + 1))));
    chk("f5_wake_early", wake, 0);
    idle();
    chk("f5_wake", wake, 1);
    chk("f5_dv", dv, 1);
    chk("f5_ovf", ovf, 0);
    chk("f5_serr", serr, 0);
    chk("f5_p0", pix[0][0], 1);
    chk("f5_p460", pix[4][60], 31);
    chk("f5_p599", pix[5][99], 50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
